// File: rtl/ppu_px_mixer_pkg.sv
// Shared PPU pixel types, OAM attribute bit positions and the palette lookup helper.
// Purely declarative: no latency or backpressure of its own.
package ppu_pkg;

    localparam int ATTR_PRIO  = 7;
    localparam int ATTR_XFLIP = 5;
    localparam int ATTR_PAL   = 4;

    typedef logic [1:0] bg_px_t;

    typedef struct packed {
        logic [1:0] colour;
        logic       pal;
        logic       prio;
    } sp_px_t;

    // Two-bit field idx of a DMG-style palette register.
    function automatic logic [1:0] pal_lookup(input logic [7:0] pal, input logic [1:0] idx);
        case (idx)
            2'd0:    return pal[1:0];
            2'd1:    return pal[3:2];
            2'd2:    return pal[5:4];
            default: return pal[7:6];
        endcase
    endfunction

endpackage

// File: rtl/ppu_px_mixer_if.sv
// Fetcher-to-mixer-to-LCD bus: row pushes, palettes, enables and the pixel valid/ready output.
// Wiring only; the slave modport is the mixer, the master is the fetcher/display side.
interface ppu_px_mixer_if #(parameter int CNT_W = 5);

    logic             line_start;
    logic [2:0]       fine_x;
    logic [7:0]       bg_lo;
    logic [7:0]       bg_hi;
    logic             bg_push;
    logic             bg_room;
    logic [7:0]       sp_lo;
    logic [7:0]       sp_hi;
    logic [7:0]       sp_attr;
    logic             sp_push;
    logic [7:0]       bgp;
    logic [7:0]       obp0;
    logic [7:0]       obp1;
    logic             bg_en;
    logic             sp_en;
    logic             px_ready;
    logic [1:0]       px_out;
    logic             px_valid;
    logic [CNT_W-1:0] bg_count;
    logic             ovf;

    modport master (
        output line_start, fine_x, bg_lo, bg_hi, bg_push, sp_lo, sp_hi, sp_attr, sp_push,
               bgp, obp0, obp1, bg_en, sp_en, px_ready,
        input  bg_room, px_out, px_valid, bg_count, ovf
    );

    modport slave (
        input  line_start, fine_x, bg_lo, bg_hi, bg_push, sp_lo, sp_hi, sp_attr, sp_push,
               bgp, obp0, obp1, bg_en, sp_en, px_ready,
        output bg_room, px_out, px_valid, bg_count, ovf
    );

endinterface

// File: rtl/ppu_bg_fifo.sv
// Circular BG pixel FIFO: 8-pixel row push, 1-pixel pop, head visible combinationally.
// Occupancy updates one cycle after push/pop; caller must only push while room=1.
module ppu_bg_fifo
    import ppu_pkg::*;
#(
    parameter int BG_DEPTH = 16,
    parameter int CNT_W    = $clog2(BG_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [7:0]       lo,
    input  logic [7:0]       hi,
    input  logic             pop,
    output bg_px_t           head,
    output logic [CNT_W-1:0] count,
    output logic             room
);

    localparam int PTR_W = (BG_DEPTH > 1) ? $clog2(BG_DEPTH) : 1;

    bg_px_t           mem [BG_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Modular advance so non-power-of-two depths (e.g. 24) still wrap correctly.
    function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= BG_DEPTH) s = s - BG_DEPTH;
        return s[PTR_W-1:0];
    endfunction

    assign head = mem[rd_ptr];
    assign room = (CNT_W'(BG_DEPTH) - count) >= CNT_W'(8);

    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < 8; k++) begin
                mem[wrap(wr_ptr, k)] <= {hi[7-k], lo[7-k]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wrap(wr_ptr, 8);
            if (pop)  rd_ptr <= wrap(rd_ptr, 1);
            count <= count + (push ? CNT_W'(8) : CNT_W'(0)) - (pop ? CNT_W'(1) : CNT_W'(0));
        end
    end

endmodule

// File: rtl/ppu_px_mixer.sv
// BG/sprite pixel mixer: fine-scroll discard, sprite merge, palettes; one registered pixel per pop.
// Latency 1 cycle pop->px_valid; pops stall on px_ready=0. PPU_SPRITE_XFLIP_EN enables attr[5] X-flip.
module ppu_px_mixer
    import ppu_pkg::*;
#(
    parameter int BG_DEPTH = 16,
    parameter int SP_DEPTH = 8,
    parameter int CNT_W    = $clog2(BG_DEPTH + 1)
) (
    input logic           clk,
    input logic           rst,
    ppu_px_mixer_if.slave px
);

    localparam int SP_W = $clog2(SP_DEPTH + 1);

    bg_px_t           bg_head;
    logic [CNT_W-1:0] bg_count;
    logic             bg_room;
    logic             bg_wr;
    logic             pop;

    sp_px_t           sp_q [SP_DEPTH];
    logic [SP_W-1:0]  sp_cnt;
    logic [2:0]       disc;
    logic [7:0]       sp_lo_m;
    logic [7:0]       sp_hi_m;
    sp_px_t           sp_head;
    bg_px_t           bgc;
    logic [1:0]       mix;

    assign bg_wr = px.bg_push && bg_room && !px.line_start;
    assign pop   = (bg_count != '0) && px.px_ready && !px.sp_push && !px.line_start;

    ppu_bg_fifo #(.BG_DEPTH(BG_DEPTH), .CNT_W(CNT_W)) u_bg_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (px.line_start),
        .push  (bg_wr),
        .lo    (px.bg_lo),
        .hi    (px.bg_hi),
        .pop   (pop),
        .head  (bg_head),
        .count (bg_count),
        .room  (bg_room)
    );

    assign px.bg_count = bg_count;
    assign px.bg_room  = bg_room;

`ifdef PPU_SPRITE_XFLIP_EN
    always_comb begin
        sp_lo_m = px.sp_lo;
        sp_hi_m = px.sp_hi;
        if (px.sp_attr[ATTR_XFLIP]) begin
            for (int b = 0; b < 8; b++) begin
                sp_lo_m[b] = px.sp_lo[7-b];
                sp_hi_m[b] = px.sp_hi[7-b];
            end
        end
    end
`else
    assign sp_lo_m = px.sp_lo;
    assign sp_hi_m = px.sp_hi;
`endif

    assign sp_head = (sp_cnt != '0) ? sp_q[0] : '0;
    assign bgc     = px.bg_en ? bg_head : 2'd0;

    always_comb begin
        mix = pal_lookup(px.bgp, bgc);
        if (px.sp_en && sp_head.colour != 2'd0 && !(sp_head.prio && bgc != 2'd0)) begin
            mix = pal_lookup(sp_head.pal ? px.obp1 : px.obp0, sp_head.colour);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SP_DEPTH; i++) sp_q[i] <= '0;
            sp_cnt      <= '0;
            disc        <= '0;
            px.px_out   <= 2'd0;
            px.px_valid <= 1'b0;
            px.ovf      <= 1'b0;
        end else begin
            px.px_valid <= 1'b0;
            if (px.bg_push && !bg_room && !px.line_start) px.ovf <= 1'b1;
            if (px.line_start) begin
                for (int i = 0; i < SP_DEPTH; i++) sp_q[i] <= '0;
                sp_cnt <= '0;
                disc   <= px.fine_x;
            end else if (px.sp_push) begin
                // Occupied opaque slots belong to an earlier (lower-X) sprite and win.
                for (int i = 0; i < SP_DEPTH; i++) begin
                    if (sp_q[i].colour == 2'd0 || SP_W'(i) >= sp_cnt) begin
                        sp_q[i] <= '{colour: {sp_hi_m[7-i], sp_lo_m[7-i]},
                                     pal:    px.sp_attr[ATTR_PAL],
                                     prio:   px.sp_attr[ATTR_PRIO]};
                    end
                end
                sp_cnt <= SP_W'(SP_DEPTH);
            end else if (pop) begin
                if (sp_cnt != '0) begin
                    for (int i = 0; i < SP_DEPTH - 1; i++) sp_q[i] <= sp_q[i+1];
                    sp_q[SP_DEPTH-1] <= '0;
                    sp_cnt <= sp_cnt - SP_W'(1);
                end
                if (disc != 3'd0) begin
                    disc <= disc - 3'd1;
                end else begin
                    px.px_valid <= 1'b1;
                    px.px_out   <= mix;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppu_px_mixer.sv
// Scoreboard bench for ppu_px_mixer: expected shades queued at stimulus time, compared on px_valid.
// Honours PPU_SPRITE_XFLIP_EN when computing the flipped-sprite expectation.
module tb_ppu_px_mixer;

    localparam int BG_DEPTH = 16;
    localparam int CNT_W    = $clog2(BG_DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_q[$];
    int   vcyc[$];

    ppu_px_mixer_if #(.CNT_W(CNT_W)) bus();

    ppu_px_mixer #(.BG_DEPTH(BG_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .px  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.px_valid) begin
            int e;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            vcyc.push_back(cyc);
            check_eq("px", 32'(bus.px_out), e);
        end
    end

    function automatic int shade(input logic [7:0] pal, input int c);
        return (int'(pal) >> (2 * c)) & 3;
    endfunction

    function automatic int bg_col(input logic [7:0] lo, input logic [7:0] hi, input int k);
        return ((int'(hi) >> (7 - k)) & 1) * 2 + ((int'(lo) >> (7 - k)) & 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bg_row(input logic [7:0] lo, input logic [7:0] hi);
        bus.bg_lo = lo; bus.bg_hi = hi; bus.bg_push = 1'b1;
        tick;
        bus.bg_push = 1'b0;
    endtask

    task automatic sp_row(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] attr);
        bus.sp_lo = lo; bus.sp_hi = hi; bus.sp_attr = attr; bus.sp_push = 1'b1;
        tick;
        bus.sp_push = 1'b0;
    endtask

    task automatic new_line(input logic [2:0] fx);
        bus.px_ready = 1'b0;
        bus.fine_x = fx; bus.line_start = 1'b1;
        tick;
        bus.line_start = 1'b0;
        vcyc.delete();
    endtask

    task automatic drain(input string tag);
        bus.px_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick;
        repeat (4) tick;
        check_eq(tag, exp_q.size(), 0);
        bus.px_ready = 1'b0;
    endtask

    initial begin
        bus.line_start = 0; bus.fine_x = 0; bus.bg_lo = 0; bus.bg_hi = 0; bus.bg_push = 0;
        bus.sp_lo = 0; bus.sp_hi = 0; bus.sp_attr = 0; bus.sp_push = 0;
        bus.bgp = 8'hE4; bus.obp0 = 8'hE4; bus.obp1 = 8'hE4;
        bus.bg_en = 1; bus.sp_en = 1; bus.px_ready = 0;
        repeat (3) tick;
        rst = 1'b0;
        check_eq("rst_valid", 32'(bus.px_valid), 0);
        check_eq("rst_out",   32'(bus.px_out),   0);
        check_eq("rst_count", 32'(bus.bg_count), 0);
        check_eq("rst_room",  32'(bus.bg_room),  1);
        check_eq("rst_ovf",   32'(bus.ovf),      0);

        // Plain BG row, all colour 1, streaming out on consecutive cycles.
        vcyc.delete();
        bus.px_ready = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(shade(8'hE4, 1));
        bg_row(8'hFF, 8'h00);
        drain("a_drain");
        check_eq("a_npx", vcyc.size(), 8);
        if (vcyc.size() == 8) check_eq("a_burst", vcyc[7] - vcyc[0], 7);

        // Fine scroll discard of 3 pixels over 16, with a non-identity palette.
        new_line(3'd3);
        bus.bgp = 8'h1B;
        for (int n = 3; n < 16; n++) begin
            exp_q.push_back(n < 8 ? shade(8'h1B, bg_col(8'hA6, 8'hCA, n))
                                  : shade(8'h1B, bg_col(8'h3C, 8'h96, n - 8)));
        end
        bg_row(8'hA6, 8'hCA);
        bg_row(8'h3C, 8'h96);
        drain("b_drain");
        check_eq("b_npx", vcyc.size(), 13);
        bus.bgp = 8'hE4;

        // Opaque sprite over BG colour 2, then BG-priority sprite over colour 2 and colour 0.
        new_line(3'd0);
        for (int k = 0; k < 8; k++) exp_q.push_back(k < 4 ? shade(8'hE4, 1) : shade(8'hE4, 2));
        bg_row(8'h00, 8'hFF);
        sp_row(8'hF0, 8'h00, 8'h00);
        drain("c_drain");

        new_line(3'd0);
        bus.obp0 = 8'h9C;
        for (int k = 0; k < 8; k++) exp_q.push_back(shade(8'hE4, 2));
        bg_row(8'h00, 8'hFF);
        sp_row(8'hF0, 8'h00, 8'h80);
        drain("d1_drain");

        new_line(3'd0);
        for (int k = 0; k < 8; k++) exp_q.push_back(k < 4 ? shade(8'h9C, 1) : shade(8'hE4, 0));
        bg_row(8'h00, 8'h00);
        sp_row(8'hF0, 8'h00, 8'h80);
        drain("d2_drain");

        // Two overlapping sprites: the earlier one keeps its opaque pixels.
        new_line(3'd0);
        bus.obp0 = 8'hE4; bus.obp1 = 8'h0C;
        for (int k = 0; k < 8; k++) exp_q.push_back(k < 2 ? shade(8'hE4, 1) : shade(8'h0C, 1));
        bg_row(8'h00, 8'h00);
        sp_row(8'hC0, 8'h00, 8'h00);
        sp_row(8'hFF, 8'h00, 8'h10);
        drain("e_drain");

        // Sprite loaded with BG empty must be held until BG arrives; X-flip build dependent.
        new_line(3'd0);
        bus.obp0 = 8'h9C;
        sp_row(8'h01, 8'h00, 8'h20);
        bus.px_ready = 1'b1;
        repeat (3) tick;
        check_eq("g_idle_valid", 32'(bus.px_valid), 0);
        for (int k = 0; k < 8; k++) begin
`ifdef PPU_SPRITE_XFLIP_EN
            exp_q.push_back(k == 0 ? shade(8'h9C, 1) : shade(8'hE4, 0));
`else
            exp_q.push_back(k == 7 ? shade(8'h9C, 1) : shade(8'hE4, 0));
`endif
        end
        bg_row(8'h00, 8'h00);
        drain("g_drain");

        // Push a second row while the first is popping.
        new_line(3'd0);
        bus.px_ready = 1'b1;
        for (int n = 0; n < 16; n++)
            exp_q.push_back(n < 8 ? bg_col(8'h5A, 8'h33, n) : bg_col(8'hC3, 8'h0F, n - 8));
        bg_row(8'h5A, 8'h33);
        bg_row(8'hC3, 8'h0F);
        drain("h_drain");
        check_eq("h_npx", vcyc.size(), 16);

        // Overflow: fill to capacity, push once more, then line_start must not clear ovf.
        new_line(3'd0);
        bg_row(8'h11, 8'h22);
        bg_row(8'h33, 8'h44);
        check_eq("f_count16", 32'(bus.bg_count), 16);
        check_eq("f_room0",   32'(bus.bg_room),  0);
        check_eq("f_ovf0",    32'(bus.ovf),      0);
        bg_row(8'h55, 8'h66);
        check_eq("f_ovf1",    32'(bus.ovf),      1);
        check_eq("f_count",   32'(bus.bg_count), 16);
        new_line(3'd0);
        check_eq("f_ovf_held", 32'(bus.ovf),      1);
        check_eq("f_flush",    32'(bus.bg_count), 0);
        check_eq("f_room1",    32'(bus.bg_room),  1);
        check_eq("f_valid",    32'(bus.px_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
